// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
// Covers FSM states, RV32I funct3 codes, lane masks and request legality helpers.
package mem_pkg;

   typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR, RESP} state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
   localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;

   typedef struct packed {
      logic        we;
      logic [2:0]  funct3;
      logic [31:0] wdata;
   } mem_req_t;

   // Unsigned variants exist only for loads.
   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      case (f3)
         F3_B, F3_H, F3_W: return 1'b1;
         F3_BU, F3_HU:     return !we;
         default:          return 1'b0;
      endcase
   endfunction

   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
      case (f3)
         F3_H, F3_HU: return a[0];
         F3_W:        return a != 2'b00;
         default:     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/load_aligner.sv
// Selects the byte/half lane of a loaded word and applies sign or zero extension.
module load_aligner
   import mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [31:0] b_shift, h_shift;
   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      b_shift = word >> {addr, 3'b000};
      h_shift = word >> {addr[1], 4'b0000};
      b       = b_shift[7:0];
      h       = h_shift[15:0];
      case (funct3)
         F3_B:    data = {{24{b[7]}}, b};
         F3_H:    data = {{16{h[15]}}, h};
         F3_BU:   data = {24'h0, b};
         F3_HU:   data = {16'h0, h};
         default: data = word;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder for a word-wide SRAM without byte enables.
// Sub-word stores use read-modify-write; loads return extended data in a one-cycle response.
module dmem_responder
   import mem_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              sram_en,
   output logic              sram_we,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [31:0]       sram_wdata,
   input  logic [31:0]       sram_rdata
);

   state_t              state, state_nx;
   mem_req_t            req_q;
   logic [ADDR_W+1:0]   addr_q;
   logic                err_q;
   logic [31:0]         word_q, rdata_q;
   logic [31:0]         ld_data, merged;
   logic [4:0]          b_sh, h_sh;
   logic                acc, acc_err;

   // Upper address bits wrap away modulo the SRAM size.
   logic unused_addr_hi;
   assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

   assign acc     = req_valid && req_ready;
   assign acc_err = !f3_legal(req_we, req_funct3) || misaligned(req_funct3, req_addr[1:0]);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (acc_err)                          state_nx = RESP;
               else if (req_we && req_funct3 == F3_W) state_nx = WR;
               else                                  state_nx = RD_ISSUE;
            end
         end
         RD_ISSUE: state_nx = RD_WAIT;
         RD_WAIT:  state_nx = req_q.we ? WR : RESP;
         WR:       state_nx = RESP;
         RESP:     state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   load_aligner u_align (
      .word   (sram_rdata),
      .addr   (addr_q[1:0]),
      .funct3 (req_q.funct3),
      .data   (ld_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         req_q   <= '0;
         addr_q  <= '0;
         err_q   <= 1'b0;
         word_q  <= '0;
         rdata_q <= '0;
      end else begin
         if (acc) begin
            req_q  <= '{we: req_we, funct3: req_funct3, wdata: req_wdata};
            addr_q <= req_addr[ADDR_W+1:0];
            err_q  <= acc_err;
         end
         if (state == RD_WAIT) word_q <= sram_rdata;
         // Load data is extended straight off the SRAM so it is registered for RESP.
         if (state == RD_WAIT && !req_q.we) rdata_q <= ld_data;
         else if (state == RESP)            rdata_q <= '0;
      end
   end

   always_comb begin
      b_sh = {addr_q[1:0], 3'b000};
      h_sh = {addr_q[1], 4'b0000};
      case (req_q.funct3)
         F3_B:    merged = (word_q & ~(BYTE_MASK << b_sh)) | ((req_q.wdata & BYTE_MASK) << b_sh);
         F3_H:    merged = (word_q & ~(HALF_MASK << h_sh)) | ((req_q.wdata & HALF_MASK) << h_sh);
         default: merged = req_q.wdata;
      endcase
   end

   // Strobes are gated by rst so an interrupted RMW never reaches the SRAM.
   always_comb begin
      req_ready  = (state == IDLE);
      sram_en    = !rst && (state == RD_ISSUE || state == WR);
      sram_we    = !rst && (state == WR);
      sram_addr  = addr_q[ADDR_W+1:2];
      sram_wdata = merged;
      resp_valid = !rst && (state == RESP);
      resp_err   = resp_valid && err_q;
      resp_rdata = resp_valid ? rdata_q : '0;
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a behavioural single-port SRAM.
module tb_dmem_responder;

   localparam int ADDR_W = 10;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid, req_ready, req_we;
   logic [2:0]        req_funct3;
   logic [31:0]       req_addr, req_wdata;
   logic              resp_valid, resp_err;
   logic [31:0]       resp_rdata;
   logic              sram_en, sram_we;
   logic [ADDR_W-1:0] sram_addr;
   logic [31:0]       sram_wdata, sram_rdata;

   always #5 clk = ~clk;

   dmem_responder #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   // SRAM model with a back-door load port for preloading words.
   logic [31:0]       mem [0:(1<<ADDR_W)-1];
   logic              bl_we;
   logic [ADDR_W-1:0] bl_addr;
   logic [31:0]       bl_data;
   int                wr_cnt = 0;

   always @(posedge clk) begin
      if (bl_we) mem[bl_addr] <= bl_data;
      else if (sram_en && sram_we) begin
         mem[sram_addr] <= sram_wdata;
         wr_cnt         <= wr_cnt + 1;
      end
      if (sram_en && !sram_we) sram_rdata <= mem[sram_addr];
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic poke(input logic [ADDR_W-1:0] a, input logic [31:0] d);
      bl_addr = a; bl_data = d; bl_we = 1'b1;
      @(posedge clk); #1;
      bl_we = 1'b0;
   endtask

   logic [31:0] r_rdata;
   logic        r_err;
   int          r_lat, r_en, r_we, r_rd_at, r_wr_at;

   // Issues one request and records the response and SRAM activity per cycle after accept.
   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      int n;
      n = 0;
      req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d; req_valid = 1'b1;
      while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
      if (!req_ready) chk("ready_timeout", {31'b0, req_ready}, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      r_lat = 1; r_en = 0; r_we = 0; r_rd_at = 0; r_wr_at = 0;
      for (int k = 0; k < 20; k++) begin
         if (sram_en) begin
            r_en++;
            if (sram_we) begin r_we++; r_wr_at = r_lat; end
            else r_rd_at = r_lat;
         end
         if (resp_valid) break;
         @(posedge clk); #1;
         r_lat++;
      end
      if (!resp_valid) chk("resp_timeout", {31'b0, resp_valid}, 32'd1);
      r_rdata = resp_rdata;
      r_err   = resp_err;
   endtask

   logic [31:0] sw_a [4];
   logic [31:0] sw_d [4];
   int          rc [4];
   int          na, nr, wc0;
   logic        acc;

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
      req_addr = '0; req_wdata = '0; bl_we = 1'b0; bl_addr = '0; bl_data = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_en", {31'b0, sram_en}, 32'd0);
      chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      rst = 1'b0;
      #1;
      chk("rst_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_rdata", resp_rdata, 32'h0);
      chk("rst_err", {31'b0, resp_err}, 32'd0);
      chk("rst_we", {31'b0, sram_we}, 32'd0);

      // LW
      poke(10'd4, 32'hDEADBEEF);
      do_req(1'b0, 3'b010, 32'h10, 32'h0);
      chk("lw_data", r_rdata, 32'hDEADBEEF);
      chk("lw_err", {31'b0, r_err}, 32'd0);
      chk("lw_lat", r_lat, 3);
      chk("lw_rd_pulses", r_en, 1);
      chk("lw_rd_at", r_rd_at, 1);
      @(posedge clk); #1;
      chk("lw_resp_pulse", {31'b0, resp_valid}, 32'd0);

      // Sign/zero extension
      poke(10'd4, 32'h80FF7F01);
      do_req(1'b0, 3'b000, 32'h13, 32'h0);
      chk("lb_13", r_rdata, 32'hFFFFFF80);
      do_req(1'b0, 3'b100, 32'h13, 32'h0);
      chk("lbu_13", r_rdata, 32'h00000080);
      do_req(1'b0, 3'b001, 32'h12, 32'h0);
      chk("lh_12", r_rdata, 32'hFFFF80FF);
      do_req(1'b0, 3'b101, 32'h10, 32'h0);
      chk("lhu_10", r_rdata, 32'h00007F01);
      do_req(1'b0, 3'b000, 32'h10, 32'h0);
      chk("lb_10", r_rdata, 32'h00000001);

      // SB read-modify-write
      poke(10'd4, 32'h11223344);
      do_req(1'b1, 3'b000, 32'h12, 32'h000000AB);
      chk("sb_rd_at", r_rd_at, 1);
      chk("sb_wr_at", r_wr_at, 3);
      chk("sb_lat", r_lat, 4);
      chk("sb_rdata", r_rdata, 32'h0);
      chk("sb_mem", mem[4], 32'h11AB3344);
      do_req(1'b0, 3'b010, 32'h10, 32'h0);
      chk("sb_readback", r_rdata, 32'h11AB3344);

      // SH into upper half
      poke(10'd5, 32'h01234567);
      do_req(1'b1, 3'b001, 32'h16, 32'hCAFEBEEF);
      chk("sh_lat", r_lat, 4);
      chk("sh_mem", mem[5], 32'hBEEF4567);

      // Address wrap: 0x1010 aliases word 4
      do_req(1'b0, 3'b010, 32'h0000_1010, 32'h0);
      chk("wrap_lw", r_rdata, 32'h11AB3344);

      // Errors
      do_req(1'b1, 3'b001, 32'h11, 32'h1234);
      chk("sh_mis_err", {31'b0, r_err}, 32'd1);
      chk("sh_mis_lat", r_lat, 1);
      chk("sh_mis_en", r_en, 0);
      do_req(1'b0, 3'b011, 32'h10, 32'h0);
      chk("f3_011_err", {31'b0, r_err}, 32'd1);
      chk("f3_011_lat", r_lat, 1);
      chk("f3_011_en", r_en, 0);
      chk("f3_011_rdata", r_rdata, 32'h0);
      do_req(1'b1, 3'b100, 32'h10, 32'h0);
      chk("sbu_err", {31'b0, r_err}, 32'd1);
      do_req(1'b0, 3'b010, 32'h12, 32'h0);
      chk("lw_mis_err", {31'b0, r_err}, 32'd1);

      // Reset while in WR of an SH
      poke(10'd8, 32'h55667788);
      wc0 = wr_cnt;
      req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h20; req_wdata = 32'h1234;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rstwr_in_wr", {31'b0, sram_we}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rstwr_we_gated", {31'b0, sram_we}, 32'd0);
      chk("rstwr_en_gated", {31'b0, sram_en}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("rstwr_ready", {31'b0, req_ready}, 32'd1);
      chk("rstwr_mem", mem[8], 32'h55667788);
      chk("rstwr_wr_cnt", wr_cnt, wc0);
      na = 0;
      for (int c = 0; c < 4; c++) begin
         if (resp_valid) na++;
         @(posedge clk); #1;
      end
      chk("rstwr_no_resp", na, 0);

      // Four SW back-to-back with req_valid held high
      sw_a = '{32'h40, 32'h44, 32'h48, 32'h4C};
      sw_d = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
      na = 0; nr = 0;
      req_we = 1'b1; req_funct3 = 3'b010; req_addr = sw_a[0]; req_wdata = sw_d[0];
      req_valid = 1'b1;
      for (int c = 0; c < 40 && nr < 4; c++) begin
         if (resp_valid) begin rc[nr] = c; nr++; end
         acc = req_valid && req_ready;
         @(posedge clk); #1;
         if (acc) begin
            na++;
            if (na < 4) begin req_addr = sw_a[na]; req_wdata = sw_d[na]; end
            else req_valid = 1'b0;
         end
      end
      req_valid = 1'b0;
      chk("b2b_accepts", na, 4);
      chk("b2b_resps", nr, 4);
      if (nr == 4) begin
         chk("b2b_gap1", rc[1] - rc[0], 3);
         chk("b2b_gap2", rc[2] - rc[1], 3);
         chk("b2b_gap3", rc[3] - rc[2], 3);
      end
      chk("b2b_mem0", mem[16], 32'hA0A0A0A0);
      chk("b2b_mem1", mem[17], 32'hB1B1B1B1);
      chk("b2b_mem2", mem[18], 32'hC2C2C2C2);
      chk("b2b_mem3", mem[19], 32'hD3D3D3D3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the multi-cycle RV32I core. It accepts one load or store request at a time from the core's MEMORY stage and performs it against a word-wide, single-port synchronous SRAM that has no byte enables. Byte and halfword stores use read-modify-write. Loads return sign- or zero-extended data.

## Interface
Parameters:
- ADDR_W, 10: SRAM word-address width, giving a depth of 2^ADDR_W words.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3.
  - Load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Store: 000 SB, 001 SH, 010 SW.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low bytes are used for SB and SH.
- resp_valid  out  1  one-cycle pulse marking completion.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  qualified by resp_valid; misaligned access or illegal funct3.
- sram_en  out  1  SRAM access strobe.
- sram_we  out  1  SRAM write strobe.
- sram_addr  out  ADDR_W  word address.
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data, valid one cycle after a read strobe.

## Operation
- Handshake and request capture:
  - A request transfers on a cycle with req_valid && req_ready.
  - On transfer, req_we, req_funct3, req_addr and req_wdata are registered.
  - Request inputs are ignored outside IDLE.
- Word address: sram_addr = addr_q[ADDR_W+1:2]. Address bits above ADDR_W+1 are ignored, so addresses wrap modulo the SRAM size.
- Error check, done at accept:
  - Halfword access with addr[0]=1 is an error.
  - Word access with addr[1:0]≠00 is an error.
  - Any funct3 not listed in the Interface is an error.
  - An errored request makes no SRAM access and goes straight to RESP with resp_err=1.
- States: IDLE, RD_ISSUE, RD_WAIT, WR, RESP.
  - IDLE → RD_ISSUE for a load, SB or SH.
  - IDLE → WR for SW.
  - IDLE → RESP for an error.
  - RD_ISSUE: sram_en=1, sram_we=0; next state RD_WAIT.
  - RD_WAIT: sram_rdata is captured into word_q. A load goes next to RESP; SB or SH goes next to WR.
  - WR: sram_en=1, sram_we=1. sram_wdata is req_wdata for SW, or word_q with the byte/half lane at addr[1:0] replaced for SB/SH. Next state RESP.
  - RESP: resp_valid=1 for this cycle only; next state IDLE.
- Load extension:
  - The byte lane is addr[1:0]; the half lane is addr[1].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- resp_rdata is registered and is driven only during RESP; otherwise it is 0.
- There is no response back-pressure: the core must sample resp_valid.

## Timing
Latency is measured from the accept edge T to the cycle with resp_valid high:
- Load: RD_ISSUE at T+1, RD_WAIT at T+2, resp_valid at T+3.
- SW: sram write strobe at T+1, resp_valid at T+2.
- SB/SH: read at T+1, capture at T+2, write at T+3, resp_valid at T+4.
- Error: resp_valid at T+1.

Back-to-back requests: req_ready returns high in the cycle after RESP, so the next accept can occur at the earliest one cycle after resp_valid.

Reset:
- Next state is IDLE.
- resp_valid, resp_err, resp_rdata, sram_en and sram_we are 0; req_ready is 1 after the reset edge.
- sram_we and sram_en are gated by !rst, so no SRAM write occurs in a cycle where rst=1, even from state WR. An aborted RMW therefore leaves memory unmodified.
- After reset, any pending request is dropped and no response is produced for it.

## Structure
- The package mem_pkg holds:
  - the state_t enum;
  - the funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the lane-select helper constants.
- The combinational sub-module load_aligner (inputs word, addr[1:0], funct3; output extended data) does lane selection and extension. It is shared by verification as a reference model.
- The store-merge logic stays inline in dmem_responder.

## Test plan
- LW at 0x0000_0010, with SRAM word 4 = 0xDEADBEEF:
  - resp_rdata = 0xDEADBEEF and resp_err=0, three cycles after accept;
  - exactly one sram_en read pulse.
- LB at 0x13 and LBU at 0x13, with word 4 = 0x80FF7F01:
  - LB returns 0xFFFFFF80;
  - LBU returns 0x00000080.
- SB of data 0x000000AB at 0x12, with word 4 = 0x11223344:
  - read at T+1, write 0x11AB3344 at T+3, resp at T+4;
  - a following LW at 0x10 returns 0x11AB3344.
- SH at 0x11 (misaligned) and a load with funct3=011:
  - each gives resp_err=1 at T+1;
  - zero sram_en pulses.
- Reset asserted while in state WR during an SH:
  - no sram_we pulse;
  - IDLE and req_ready=1 after the reset edge;
  - the SRAM word is unchanged.
- req_valid held high for four SW requests in a row:
  - each accepted only in IDLE;
  - responses spaced three cycles apart;
  - the SRAM ends with all four words written.
